mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 31 +++
 rtl/mem_port_arb.sv | 136 +++++++++++++
 tb/tb_mem_port_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: controller state encoding,
// requester index constants and the round-robin successor function.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_OPND  = 2'd1;
    localparam logic [1:0] REQ_WB    = 2'd2;
    localparam logic [1:0] REQ_STACK = 2'd3;

    // Successor within the round-robin ring {fetch, operand, stack}.
    // Writeback is never part of the ring, so it maps back to fetch.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            REQ_FETCH: rr_next = REQ_OPND;
            REQ_OPND:  rr_next = REQ_STACK;
            default:   rr_next = REQ_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 3-way round-robin selector over requesters fetch, operand and
// stack. The search starts at rr and walks the ring upward, wrapping 3 to 0.
// Ports:
//   mask   in  4  request mask (bit 2 is ignored)
//   rr     in  2  current round-robin pointer
//   winner out 2  index of the selected requester
//   valid  out 1  a ring requester was found
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] rr,
    output logic [1:0] winner,
    output logic       valid
);

    always_comb begin
        logic [1:0] cand;
        winner = REQ_FETCH;
        valid  = 1'b0;
        cand   = rr;
        for (int k = 0; k < 3; k++) begin
            if (!valid && mask[cand] && cand != REQ_WB) begin
                winner = cand;
                valid  = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Single-port memory arbiter for four pipeline requesters. Writeback has
// absolute priority; fetch, operand and stack share the port round-robin.
// One transaction is in flight at a time: IDLE arbitrates, ACCESS drives the
// memory for one cycle, WAIT counts out the read latency.
// Ports:
//   clk, rst         clock (rising edge), async active-high reset
//   req, we          per-requester request and write flag
//   addr, wdata      packed per-requester address / write data
//   gnt, done        one-hot grant and completion pulses
//   rdata            read data, valid with the read completion pulse
//   stall            pipeline hold: some requester is waiting on completion
//   mem_*            memory interface
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [3:0]      we,
    input  logic [4*AW-1:0] addr,
    input  logic [4*DW-1:0] wdata,
    output logic [3:0]      gnt,
    output logic [3:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

    state_t     state;
    logic [1:0] rr;
    logic [1:0] cnt;
    logic [1:0] lat_idx;
    logic       lat_we;

    logic [1:0] rr_win;
    logic       rr_valid;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic [3:0] pick_onehot;
    logic [3:0] lat_onehot;

    rr_pick u_rr_pick (
        .mask   (req),
        .rr     (rr),
        .winner (rr_win),
        .valid  (rr_valid)
    );

    assign pick_idx    = req[REQ_WB] ? REQ_WB : rr_win;
    assign pick_valid  = req[REQ_WB] | rr_valid;
    assign pick_onehot = 4'b0001 << pick_idx;
    assign lat_onehot  = 4'b0001 << lat_idx;

    assign stall = |(req & ~done);

    // Read data only passes through during a read completion, which always
    // happens in WAIT; write completions occur in ACCESS and leave rdata at 0.
    assign rdata = (state == WAIT && done != 4'b0000) ? mem_rdata : '0;

    // mem_addr / mem_wdata double as the latched address and write data:
    // they are captured at arbitration and are only non-zero during ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= REQ_FETCH;
            cnt       <= 2'd0;
            lat_idx   <= 2'd0;
            lat_we    <= 1'b0;
            gnt       <= 4'b0000;
            done      <= 4'b0000;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= ACCESS;
                        lat_idx   <= pick_idx;
                        lat_we    <= we[pick_idx];
                        gnt       <= pick_onehot;
                        mem_en    <= 1'b1;
                        mem_we    <= we[pick_idx];
                        mem_addr  <= addr[int'(pick_idx)*AW +: AW];
                        mem_wdata <= wdata[int'(pick_idx)*DW +: DW];
                        done      <= we[pick_idx] ? pick_onehot : 4'b0000;
                        if (pick_idx != REQ_WB) begin
                            rr <= rr_next(pick_idx);
                        end
                    end
                end
                ACCESS: begin
                    gnt       <= 4'b0000;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (lat_we) begin
                        done  <= 4'b0000;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                        // With a one-cycle latency the single WAIT cycle is
                        // already the completion cycle.
                        done  <= (LAT == 1) ? lat_onehot : 4'b0000;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= IDLE;
                        done  <= 4'b0000;
                    end else begin
                        cnt  <= cnt - 2'd1;
                        done <= (cnt == 2'd1) ? lat_onehot : 4'b0000;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
    import mem_arb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [3:0]      gnt;
    logic [3:0]      done;
    logic [DW-1:0]   rdata;
    logic            stall;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arb #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .stall     (stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        we  = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Advance until a grant appears, bounded to 10 cycles; g stays 0 on timeout
    // and the caller's comparison then reports it.
    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0000;
        for (int i = 0; i < 10 && g == 4'b0000; i++) begin
            tick();
            g = gnt;
        end
    endtask

    logic [3:0] g;
    logic [3:0] seen_done;
    logic       seen_en;

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        we        = 4'b0000;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;

        // Reset state
        do_reset();
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);

        // Single read, LAT=2
        mem_rdata  = 16'hBEEF;
        addr[7:0]  = 8'h10;
        we         = 4'b0000;
        req        = 4'b0001;
        #1;
        check("rd_stall_t0", 32'(stall), 32'h1);
        tick();
        check("rd_gnt_t1", 32'(gnt), 32'h1);
        check("rd_en_t1", 32'(mem_en), 32'h1);
        check("rd_we_t1", 32'(mem_we), 32'h0);
        check("rd_done_t1", 32'(done), 32'h0);
        addr[7:0] = 8'h55;
        req       = 4'b0000;
        #1;
        check("rd_addr_latched", 32'(mem_addr), 32'h10);
        check("rd_stall_drop", 32'(stall), 32'h0);
        tick();
        check("rd_state_t2", 32'(dut.state), 32'(WAIT));
        check("rd_en_t2", 32'(mem_en), 32'h0);
        check("rd_addr_t2", 32'(mem_addr), 32'h0);
        check("rd_done_t2", 32'(done), 32'h0);
        check("rd_rdata_t2", 32'(rdata), 32'h0);
        tick();
        check("rd_done_t3", 32'(done), 32'h1);
        check("rd_rdata_t3", 32'(rdata), 32'hBEEF);
        tick();
        check("rd_state_t4", 32'(dut.state), 32'(IDLE));
        check("rd_done_t4", 32'(done), 32'h0);
        check("rd_rdata_t4", 32'(rdata), 32'h0);

        // Single write from writeback
        req           = 4'b0100;
        we            = 4'b0100;
        addr[23:16]   = 8'h20;
        wdata[47:32]  = 16'h1234;
        tick();
        check("wr_gnt", 32'(gnt), 32'h4);
        check("wr_en", 32'(mem_en), 32'h1);
        check("wr_we", 32'(mem_we), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'h20);
        check("wr_wdata", 32'(mem_wdata), 32'h1234);
        check("wr_done", 32'(done), 32'h4);
        check("wr_rdata", 32'(rdata), 32'h0);
        req = 4'b0000;
        tick();
        check("wr_state_t2", 32'(dut.state), 32'(IDLE));
        check("wr_en_t2", 32'(mem_en), 32'h0);
        check("wr_wdata_t2", 32'(mem_wdata), 32'h0);
        check("wr_done_t2", 32'(done), 32'h0);

        // Priority: writeback wins while held, then round-robin 0,1,3,0
        do_reset();
        we  = 4'b1111;
        req = 4'b1111;
        wait_gnt(g);
        check("pri_g0", 32'(g), 32'h4);
        wait_gnt(g);
        check("pri_g1", 32'(g), 32'h4);
        req = 4'b1011;
        wait_gnt(g);
        check("pri_g2", 32'(g), 32'h1);
        wait_gnt(g);
        check("pri_g3", 32'(g), 32'h2);
        wait_gnt(g);
        check("pri_g4", 32'(g), 32'h8);
        wait_gnt(g);
        check("pri_g5", 32'(g), 32'h1);
        req = 4'b0000;
        tick();
        tick();

        // Round-robin reads with wrap 3 -> 0
        do_reset();
        we  = 4'b0000;
        req = 4'b1011;
        wait_gnt(g);
        check("rr_g0", 32'(g), 32'h1);
        wait_gnt(g);
        check("rr_g1", 32'(g), 32'h2);
        wait_gnt(g);
        check("rr_g2", 32'(g), 32'h8);
        wait_gnt(g);
        check("rr_g3", 32'(g), 32'h1);
        req = 4'b0000;
        repeat (5) tick();

        // Reset during WAIT abandons the read
        do_reset();
        we  = 4'b0000;
        req = 4'b0001;
        tick();
        check("rw_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("rw_state_wait", 32'(dut.state), 32'(WAIT));
        rst = 1'b1;
        #1;
        check("rw_state_rst", 32'(dut.state), 32'(IDLE));
        check("rw_done_rst", 32'(done), 32'h0);
        check("rw_en_rst", 32'(mem_en), 32'h0);
        check("rw_gnt_rst", 32'(gnt), 32'h0);
        check("rw_rr_rst", 32'(dut.rr), 32'h0);
        #1;
        rst = 1'b0;
        seen_done = 4'b0000;
        seen_en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_done = seen_done | done;
            seen_en   = seen_en | mem_en;
        end
        check("rw_no_done", 32'(seen_done), 32'h0);
        check("rw_no_en", 32'(seen_en), 32'h0);
        req = 4'b1011;
        wait_gnt(g);
        check("rw_rr_first", 32'(g), 32'h1);
        req = 4'b0000;
        repeat (5) tick();

        // Withdraw: operand loses to writeback, then drops its request
        do_reset();
        we  = 4'b0100;
        req = 4'b0110;
        #1;
        check("wd_stall_t0", 32'(stall), 32'h1);
        tick();
        check("wd_gnt_wb", 32'(gnt), 32'h4);
        req = 4'b0000;
        #1;
        check("wd_stall_drop", 32'(stall), 32'h0);
        g = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            g = g | gnt;
        end
        check("wd_no_gnt", 32'(g), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
